// File: rtl/pattern_sequencer.sv
// pattern_sequencer: schedules frame-animated generators, muxes their colour, blanks between patterns
module pattern_sequencer #(
  parameter int NUM_PATTERNS  = 4,
  parameter int DWELL_FRAMES  = 600,
  parameter int BLANK_FRAMES  = 8,
  parameter int SPEED_DEFAULT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      next_frame,
  input  logic                      active,
  input  logic                      auto_en,
  input  logic                      btn_next,
  input  logic                      btn_pause,
  input  logic                      speed_up,
  input  logic                      speed_down,
  input  logic [6*NUM_PATTERNS-1:0] pattern_rgb,
  output logic [NUM_PATTERNS-1:0]   pattern_enable,
  output logic [2:0]                step_size,
  output logic [2:0]                pattern_sel,
  output logic                      in_transition,
  output logic [5:0]                rgb
);
  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam int BW = $clog2(BLANK_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
  localparam logic [2:0] SEL_LAST = 3'(NUM_PATTERNS - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t state, state_n;
  logic [2:0] sel, sel_n, step_n;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic [BW-1:0] blank_cnt, blank_n;
  logic paused, advance;
  logic [5:0] cur;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= SHOW;
      sel       <= 3'd0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      paused    <= 1'b0;
      step_size <= 3'(SPEED_DEFAULT);
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      dwell_cnt <= dwell_n;
      blank_cnt <= blank_n;
      paused    <= paused ^ btn_pause;
      step_size <= step_n;
    end

  // dwell expiry and btn_next share one advance path, so both together step sel once
  always_comb begin
    state_n = state;
    sel_n   = sel;
    dwell_n = dwell_cnt;
    blank_n = blank_cnt;
    advance = 1'b0;
    if (state == SHOW) begin
      advance = btn_next;
      if (next_frame && auto_en && !paused) begin
        if (dwell_cnt == DWELL_LAST) advance = 1'b1;
        else dwell_n = dwell_cnt + 1'b1;
      end
      if (advance) begin
        sel_n   = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
        dwell_n = '0;
        blank_n = '0;
        state_n = BLANK;
      end
    end else if (next_frame) begin
      blank_n = blank_cnt + 1'b1;
      state_n = (blank_cnt == BLANK_LAST) ? SHOW : BLANK;
    end
  end

  always_comb
    step_n = (speed_up && !speed_down && step_size != 3'd7) ? step_size + 3'd1 :
             (speed_down && !speed_up && step_size != 3'd0) ? step_size - 3'd1 : step_size;

  // enable stays on through BLANK so the incoming pattern is already animating
  always_comb begin
    cur = '0;
    pattern_enable = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (sel == 3'(i)) cur = pattern_rgb[6*i +: 6];
      pattern_enable[i] = (sel == 3'(i)) && !paused;
    end
  end

  assign rgb           = (state == SHOW && active) ? cur : 6'd0;
  assign pattern_sel   = sel;
  assign in_transition = (state == BLANK);
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: scoreboard bench against a frame-level reference model
module tb_pattern_sequencer;
  localparam int N = 3, DWELL = 4, BLANKF = 2, SPD = 2;

  logic clk = 0, rst = 1, next_frame = 0, active = 0, auto_en = 0;
  logic btn_next = 0, btn_pause = 0, speed_up = 0, speed_down = 0;
  logic [6*N-1:0] pattern_rgb = '0;
  logic [N-1:0] pattern_enable;
  logic [2:0] step_size, pattern_sel;
  logic in_transition;
  logic [5:0] rgb;

  pattern_sequencer #(
    .NUM_PATTERNS(N), .DWELL_FRAMES(DWELL), .BLANK_FRAMES(BLANKF), .SPEED_DEFAULT(SPD)
  ) dut (
    .clk(clk), .rst(rst), .next_frame(next_frame), .active(active), .auto_en(auto_en),
    .btn_next(btn_next), .btn_pause(btn_pause), .speed_up(speed_up), .speed_down(speed_down),
    .pattern_rgb(pattern_rgb), .pattern_enable(pattern_enable), .step_size(step_size),
    .pattern_sel(pattern_sel), .in_transition(in_transition), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   sel;
    logic [N-1:0] en;
    logic [2:0]   step;
    logic         tr;
    logic [5:0]   rgb;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;

  // reference model: pattern index, frames shown, frames blanked, pause flag, speed
  int m_sel, m_shown, m_blanked, m_speed;
  bit m_paused, m_blanking;

  function automatic void m_reset();
    m_sel = 0; m_shown = 0; m_blanked = 0; m_speed = SPD; m_paused = 0; m_blanking = 0;
  endfunction

  function automatic void m_step(bit nf, bit au, bit nx, bit pa, bit up, bit dn);
    bit adv;
    if (m_blanking) begin
      if (nf) begin
        m_blanked++;
        if (m_blanked == BLANKF) m_blanking = 0;
      end
    end else begin
      adv = nx;
      if (nf && au && !m_paused) begin
        if (m_shown + 1 == DWELL) adv = 1;
        else m_shown++;
      end
      if (adv) begin
        m_sel = (m_sel + 1) % N;
        m_shown = 0;
        m_blanked = 0;
        m_blanking = 1;
      end
    end
    if (pa) m_paused = !m_paused;
    if (up && !dn) m_speed = (m_speed < 7) ? m_speed + 1 : 7;
    if (dn && !up) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
  endfunction

  task automatic drive(input bit r, nf, au, nx, pa, up, dn);
    obs_t e;
    @(posedge clk);
    #1;
    rst = r; next_frame = nf; auto_en = au; btn_next = nx; btn_pause = pa;
    speed_up = up; speed_down = dn;
    active = ($urandom_range(0, 3) != 0);
    pattern_rgb = (6*N)'($urandom);
    if (r) m_reset();
    e.sel  = 3'(m_sel);
    e.en   = m_paused ? '0 : N'(1 << m_sel);
    e.step = 3'(m_speed);
    e.tr   = m_blanking;
    e.rgb  = (!m_blanking && active) ? pattern_rgb[6*m_sel +: 6] : 6'd0;
    exp_q.push_back(e);
    if (!r) m_step(nf, au, nx, pa, up, dn);
  endtask

  task automatic frames(input int n, input bit au);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, au, 0, 0, 0, 0);
      drive(0, 0, au, 0, 0, 0, 0);
    end
  endtask

  task automatic pulse(input bit nf, au, nx, pa, up, dn);
    drive(0, nf, au, nx, pa, up, dn);
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {pattern_sel, pattern_enable, step_size, in_transition, rgb};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle %0d: got sel=%0d en=%b step=%0d tr=%b rgb=%h, want sel=%0d en=%b step=%0d tr=%b rgb=%h",
                 cyc, a.sel, a.en, a.step, a.tr, a.rgb, e.sel, e.en, e.step, e.tr, e.rgb);
      end
      cyc++;
    end
  end

  initial begin
    m_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    // dwell expiry into BLANK, then through to SHOW, twice more to wrap
    frames(4, 1);
    frames(2, 1);
    frames(6, 1);
    frames(6, 1);
    // pause mid-dwell, hold, unpause, advance
    frames(2, 1);
    pulse(0, 1, 0, 1, 0, 0);
    frames(5, 1);
    pulse(0, 1, 0, 1, 0, 0);
    frames(4, 1);
    // btn_next while paused
    pulse(0, 1, 0, 1, 0, 0);
    pulse(0, 1, 1, 0, 0, 0);
    frames(3, 1);
    pulse(0, 1, 0, 1, 0, 0);
    frames(3, 1);
    // btn_next coincident with dwell expiry, then btn_next during BLANK
    frames(3, 1);
    pulse(1, 1, 1, 0, 0, 0);
    pulse(0, 1, 1, 0, 0, 0);
    pulse(1, 1, 1, 0, 0, 0);
    frames(2, 1);
    // auto_en off holds dwell count
    frames(2, 1);
    frames(5, 0);
    frames(3, 1);
    // speed saturation and simultaneous up/down
    for (int i = 0; i < 6; i++) pulse(0, 0, 0, 0, 1, 0);
    pulse(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 1, 1);
    pulse(0, 0, 0, 0, 1, 0);
    // reset mid-BLANK
    frames(1, 1);
    pulse(0, 1, 1, 0, 1, 0);
    pulse(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 60) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
